// File: rtl/cb_filter_pkg.sv
// Shared types for the counting-Bloom-filter request tracker.
package cb_filter_pkg;

  typedef logic [31:0] cb_seed_t;

  localparam cb_seed_t [2:0] EgSeeds = {32'h9e37_79b9, 32'h85eb_ca6b, 32'hc2b2_ae35};

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } cb_state_e;

endpackage

// File: rtl/cb_filter.sv
// Counting Bloom filter: K seeded XOR-fold hashes into saturation-checked bucket counters.
module cb_filter
  import cb_filter_pkg::*;
#(
  parameter int AddrWidth   = 32,
  parameter int KHashes     = 3,
  parameter int HashWidth   = 4,
  parameter int HashRounds  = 1,
  parameter int BucketWidth = 4,
  parameter cb_seed_t [KHashes-1:0] Seeds = EgSeeds
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 filter_clear_i,
  input  logic                 incr_i,
  input  logic [AddrWidth-1:0] incr_addr_i,
  input  logic                 decr_i,
  input  logic [AddrWidth-1:0] decr_addr_i,
  input  logic [AddrWidth-1:0] lookup_addr_i,
  output logic                 lookup_hit_o,
  output logic                 filter_full_o,
  output logic                 filter_error_o
);

  localparam int NumBuckets = 1 << HashWidth;
  localparam int CntMax     = (1 << BucketWidth) - 1;

  logic [BucketWidth-1:0] cnt_q [NumBuckets];
  logic [BucketWidth-1:0] cnt_d [NumBuckets];
  logic [HashWidth-1:0]   inc_h [KHashes];
  logic [HashWidth-1:0]   dec_h [KHashes];
  logic [HashWidth-1:0]   lk_h  [KHashes];

  // Each round rotates by one and re-applies the seed; the result is XOR-folded to HashWidth.
  function automatic logic [HashWidth-1:0] hash_f(input logic [AddrWidth-1:0] addr,
                                                  input cb_seed_t seed);
    logic [AddrWidth-1:0] x;
    logic [HashWidth-1:0] h;
    x = addr;
    for (int r = 0; r < HashRounds; r++) begin
      if (r != 0) x = {x[AddrWidth-2:0], x[AddrWidth-1]};
      for (int b = 0; b < AddrWidth; b++) x[b] = x[b] ^ seed[b % 32];
    end
    h = '0;
    for (int b = 0; b < AddrWidth; b++) h[b % HashWidth] = h[b % HashWidth] ^ x[b];
    return h;
  endfunction

  always_comb begin
    lookup_hit_o = 1'b1;
    for (int k = 0; k < KHashes; k++) begin
      inc_h[k] = hash_f(incr_addr_i, Seeds[k]);
      dec_h[k] = hash_f(decr_addr_i, Seeds[k]);
      lk_h[k]  = hash_f(lookup_addr_i, Seeds[k]);
      if (cnt_q[lk_h[k]] == '0) lookup_hit_o = 1'b0;
    end
  end

  always_comb begin
    int acc;
    acc            = 0;
    filter_full_o  = 1'b0;
    filter_error_o = 1'b0;
    for (int b = 0; b < NumBuckets; b++) begin
      acc = int'(cnt_q[b]);
      for (int k = 0; k < KHashes; k++) begin
        if (incr_i && inc_h[k] == HashWidth'(b)) acc++;
        if (decr_i && dec_h[k] == HashWidth'(b)) acc--;
      end
      if (acc < 0 || acc > CntMax) begin
        filter_error_o = 1'b1;
        cnt_d[b]       = cnt_q[b];
      end else begin
        cnt_d[b] = BucketWidth'(acc);
      end
      // Full leaves headroom for one more insert that lands all K hashes in one bucket.
      if (int'(cnt_q[b]) > CntMax - KHashes) filter_full_o = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int b = 0; b < NumBuckets; b++) cnt_q[b] <= '0;
    end else if (filter_clear_i) begin
      for (int b = 0; b < NumBuckets; b++) cnt_q[b] <= '0;
    end else begin
      for (int b = 0; b < NumBuckets; b++) cnt_q[b] <= cnt_d[b];
    end
  end

endmodule

// File: rtl/cb_filter_tracker.sv
// In-order request tracker: stalls requests whose address may alias an in-flight one.
// States: ST_RUN | normal operation ; ST_DRAIN | block requests until outstanding reaches 0
module cb_filter_tracker
  import cb_filter_pkg::*;
#(
  parameter int AddrWidth      = 32,
  parameter int MaxOutstanding = 8,
  parameter int KHashes        = 3,
  parameter int HashWidth      = 4,
  parameter int HashRounds     = 1,
  parameter int BucketWidth    = 4,
  parameter cb_seed_t [KHashes-1:0] Seeds = EgSeeds
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                req_valid_i,
  output logic                                req_ready_o,
  input  logic [AddrWidth-1:0]                req_addr_i,
  output logic                                req_valid_o,
  input  logic                                req_ready_i,
  output logic [AddrWidth-1:0]                req_addr_o,
  input  logic                                rsp_valid_i,
  output logic                                rsp_ready_o,
  output logic                                rsp_valid_o,
  input  logic                                rsp_ready_i,
  input  logic                                flush_i,
  output logic                                drain_done_o,
  output logic [$clog2(MaxOutstanding):0]     outstanding_o,
  output logic                                hazard_o,
  output logic                                err_o
);

  localparam int PtrW = $clog2(MaxOutstanding);
  localparam int CntW = PtrW + 1;

  logic [AddrWidth-1:0] fifo_q [MaxOutstanding];
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]      count_q, count_d;
  cb_state_e            state_q;
  logic                 err_q, drain_done_q;

  logic lookup_hit, filter_full, filter_err;
  logic stall, push, pop, rsp_hs, empty_rsp;

  cb_filter #(
    .AddrWidth  (AddrWidth),
    .KHashes    (KHashes),
    .HashWidth  (HashWidth),
    .HashRounds (HashRounds),
    .BucketWidth(BucketWidth),
    .Seeds      (Seeds)
  ) u_filter (
    .clk_i         (clk_i),
    .rst_ni        (~rst_i),
    .filter_clear_i(1'b0),
    .incr_i        (push),
    .incr_addr_i   (req_addr_i),
    .decr_i        (pop),
    .decr_addr_i   (fifo_q[rd_ptr_q]),
    .lookup_addr_i (req_addr_i),
    .lookup_hit_o  (lookup_hit),
    .filter_full_o (filter_full),
    .filter_error_o(filter_err)
  );

  always_comb begin
    hazard_o  = req_valid_i & lookup_hit;
    // rst_i is folded in so nothing is offered downstream while the tracker is held in reset.
    stall     = hazard_o | (count_q == CntW'(MaxOutstanding)) | filter_full
              | (state_q == ST_DRAIN) | err_q | rst_i;
    push      = req_valid_i & req_ready_i & ~stall;
    rsp_hs    = rsp_valid_i & rsp_ready_i;
    pop       = rsp_hs & (count_q != '0);
    empty_rsp = rsp_hs & (count_q == '0);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  assign req_valid_o   = req_valid_i & ~stall;
  assign req_ready_o   = req_ready_i & ~stall;
  assign req_addr_o    = req_addr_i;
  assign rsp_valid_o   = rsp_valid_i;
  assign rsp_ready_o   = rsp_ready_i;
  assign outstanding_o = count_q;
  assign err_o         = err_q;
  assign drain_done_o  = drain_done_q;

  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= req_addr_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      state_q      <= ST_RUN;
      err_q        <= 1'b0;
      drain_done_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q      <= count_d;
      err_q        <= err_q | empty_rsp | filter_err;
      drain_done_q <= 1'b0;
      unique case (state_q)
        ST_RUN: begin
          if (flush_i) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (count_d == '0) begin
            state_q      <= ST_RUN;
            drain_done_q <= 1'b1;
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_cb_filter_tracker.sv
// Self-checking bench for cb_filter_tracker: vector table plus hand-written corner sequences.
module tb_cb_filter_tracker;
  import cb_filter_pkg::*;

  localparam int AW = 32;
  localparam int MO = 8;
  localparam int OW = $clog2(MO) + 1;
  // Seeds whose XOR-fold values are 1, 2 and 3: addresses i<<12 then occupy disjoint buckets.
  localparam cb_seed_t [2:0] TbSeeds = {32'h3, 32'h2, 32'h1};

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          req_valid_i, req_ready_o, req_valid_o, req_ready_i;
  logic [AW-1:0] req_addr_i, req_addr_o;
  logic          rsp_valid_i, rsp_ready_o, rsp_valid_o, rsp_ready_i;
  logic          flush_i, drain_done_o, hazard_o, err_o;
  logic [OW-1:0] outstanding_o;

  always #5 clk_i = ~clk_i;

  cb_filter_tracker #(
    .AddrWidth(AW), .MaxOutstanding(MO), .KHashes(3), .HashWidth(8),
    .HashRounds(1), .BucketWidth(4), .Seeds(TbSeeds)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_addr_o(req_addr_o),
    .rsp_valid_i(rsp_valid_i), .rsp_ready_o(rsp_ready_o),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .flush_i(flush_i), .drain_done_o(drain_done_o), .outstanding_o(outstanding_o),
    .hazard_o(hazard_o), .err_o(err_o)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [AW-1:0] exp_q[$];

  typedef struct {
    logic          v;
    logic [AW-1:0] a;
    logic          rdy;
    logic          rsp;
    logic          evo;
    logic          ero;
    logic          ehz;
    int            eout;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock cycle: drive, check combinational outputs mid-cycle, then check outstanding after the edge.
  task automatic step(input logic v, input logic [AW-1:0] a, input logic rdy, input logic rsp,
                      input logic fl, input logic evo, input logic ero, input logic ehz,
                      input int eout, input string tag);
    req_valid_i = v;
    req_addr_i  = a;
    req_ready_i = rdy;
    rsp_valid_i = rsp;
    flush_i     = fl;
    #2;
    chk({tag, ".hazard"},    32'(hazard_o),    32'(ehz));
    chk({tag, ".req_valid"}, 32'(req_valid_o), 32'(evo));
    chk({tag, ".req_ready"}, 32'(req_ready_o), 32'(ero));
    if (evo && rdy) exp_q.push_back(a);
    if (req_valid_o && req_ready_i && exp_q.size() > 0)
      chk({tag, ".addr"}, req_addr_o, exp_q.pop_front());
    @(posedge clk_i);
    #1;
    chk({tag, ".outstanding"}, 32'(outstanding_o), 32'(eout));
  endtask

  task automatic reset_pulse();
    rst_i = 1'b1;
    #1;
    chk("rst.err",         32'(err_o),         32'd0);
    chk("rst.outstanding", 32'(outstanding_o), 32'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    //        v     addr       rdy   rsp   evo   ero   ehz   out
    tbl[0]  = '{1'b1, 32'h0100, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1};
    tbl[1]  = '{1'b1, 32'h0100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1};
    tbl[2]  = '{1'b1, 32'h0100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1};
    tbl[3]  = '{1'b1, 32'h0100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 0};
    tbl[4]  = '{1'b1, 32'h0100, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1};
    tbl[5]  = '{1'b1, 32'h1000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2};
    tbl[6]  = '{1'b1, 32'h2000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3};
    tbl[7]  = '{1'b1, 32'h3000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3};
    tbl[8]  = '{1'b1, 32'h0100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3};
    tbl[9]  = '{1'b0, 32'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2};
    tbl[10] = '{1'b0, 32'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1};
    tbl[11] = '{1'b0, 32'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};

    rst_i       = 1'b1;
    req_valid_i = 1'b1;
    req_ready_i = 1'b1;
    req_addr_i  = 32'h0100;
    rsp_valid_i = 1'b1;
    rsp_ready_i = 1'b1;
    flush_i     = 1'b0;
    #12;
    chk("reset.outstanding", 32'(outstanding_o), 32'd0);
    chk("reset.err",         32'(err_o),         32'd0);
    chk("reset.drain_done",  32'(drain_done_o),  32'd0);
    chk("reset.req_valid",   32'(req_valid_o),   32'd0);
    chk("reset.req_ready",   32'(req_ready_o),   32'd0);
    chk("reset.rsp_valid",   32'(rsp_valid_o),   32'(rsp_valid_i));
    chk("reset.rsp_ready",   32'(rsp_ready_o),   32'(rsp_ready_i));
    req_valid_i = 1'b0;
    rsp_valid_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    // Same-address hazard, then same-cycle push/pop at outstanding 3
    for (int i = 0; i < 12; i++)
      step(tbl[i].v, tbl[i].a, tbl[i].rdy, tbl[i].rsp, 1'b0,
           tbl[i].evo, tbl[i].ero, tbl[i].ehz, tbl[i].eout, $sformatf("vec%0d", i));

    // Fill to capacity with distinct addresses; the ninth is refused on occupancy alone
    for (int i = 1; i <= MO; i++)
      step(1'b1, AW'(i) << 12, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, i, $sformatf("fill%0d", i));
    step(1'b1, 32'h9000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, MO, "fill.ninth");
    for (int i = MO - 1; i >= 0; i--)
      step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, i, $sformatf("empty%0d", i));

    // Flush with two outstanding; flush is ignored while draining
    step(1'b1, 32'h1000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1, "d.p1");
    step(1'b1, 32'h2000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2, "d.p2");
    step(1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2, "d.flush");
    chk("d.flush.done", 32'(drain_done_o), 32'd0);
    step(1'b1, 32'h5000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2, "d.blk");
    chk("d.blk.done", 32'(drain_done_o), 32'd0);
    step(1'b1, 32'h5000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1, "d.r1");
    chk("d.r1.done", 32'(drain_done_o), 32'd0);
    step(1'b1, 32'h5000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, "d.r2");
    chk("d.r2.done", 32'(drain_done_o), 32'd1);
    step(1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, "d.idle");
    chk("d.idle.done", 32'(drain_done_o), 32'd0);

    // Flush with nothing outstanding: one DRAIN cycle then back to RUN
    step(1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, "f0.flush");
    chk("f0.flush.done", 32'(drain_done_o), 32'd0);
    step(1'b1, 32'h5000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, "f0.drain");
    chk("f0.drain.done", 32'(drain_done_o), 32'd1);
    step(1'b1, 32'h5000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1, "f0.run");
    chk("f0.run.done", 32'(drain_done_o), 32'd0);
    step(1'b0, 32'h0,    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, "f0.rsp");

    // Response with empty FIFO: sticky error, all requests stalled until reset
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, "e.rsp");
    chk("e.rsp.err", 32'(err_o), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'h5000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, $sformatf("e.stall%0d", i));
      chk($sformatf("e.stall%0d.err", i), 32'(err_o), 32'd1);
    end
    reset_pulse();
    step(1'b1, 32'h5000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1, "e.after");
    step(1'b0, 32'h0,    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, "e.after_rsp");
    chk("e.after.err", 32'(err_o), 32'd0);

    // Mid-stream asynchronous reset with four in flight
    step(1'b1, 32'h0100, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1, "r.p1");
    step(1'b1, 32'h1000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2, "r.p2");
    step(1'b1, 32'h2000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3, "r.p3");
    step(1'b1, 32'h3000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4, "r.p4");
    req_valid_i = 1'b1;
    req_addr_i  = 32'h4000;
    req_ready_i = 1'b1;
    #2;
    rst_i = 1'b1;
    #1;
    chk("r.async.outstanding", 32'(outstanding_o), 32'd0);
    chk("r.async.req_valid",   32'(req_valid_o),   32'd0);
    chk("r.async.req_ready",   32'(req_ready_o),   32'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    exp_q.delete();
    step(1'b1, 32'h0100, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1, "r.after");
    step(1'b0, 32'h0,    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, "r.after_rsp");
    chk("r.after.err", 32'(err_o), 32'd0);

    chk("scoreboard.empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
